// File: rtl/usr_pkg.sv
// Shared op codes and FSM state encodings for the universal shift engine.
package usr_pkg;

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_SRL  = 3'b001;
   localparam logic [2:0] OP_SL   = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ASR  = 3'b101;
   localparam logic [2:0] OP_LOAD = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/usr_step.sv
// Single-step next-value function of the shift register; purely combinational.
module usr_step
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q_next
);

   always_comb begin
      q_next = q;
      case (op)
         OP_SRL:  q_next = {sin_l, q[WIDTH-1:1]};
         OP_SL:   q_next = {q[WIDTH-2:0], sin_r};
         OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
         OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
         OP_LOAD: q_next = d;
         default: q_next = q;
      endcase
   end

endmodule

// File: rtl/usr_shift_engine.sv
// WIDTH-bit universal shift register with a burst sequencer (busy/done handshake).
// Define USR_PARITY_EN to drive q_par with the even parity of q; otherwise q_par is 0.
//
// state  | meaning
// S_IDLE | direct mode: ctrl applied every edge; start latches a burst
// S_RUN  | latched op applied once per edge until the step count expires
// S_DONE | one-cycle completion pulse, q holds
module usr_shift_engine
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       ctrl,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done,
   output logic             q_par
);

   state_t           state, state_nxt;
   logic [2:0]       op_q;
   logic [AMT_W-1:0] cnt;
   logic [2:0]       step_op;
   logic             q_en;
   logic [WIDTH-1:0] q_step;

   usr_step #(.WIDTH(WIDTH)) u_step (
      .op     (step_op),
      .q      (q),
      .d      (d),
      .sin_l  (sin_l),
      .sin_r  (sin_r),
      .q_next (q_step)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      step_op   = ctrl;
      q_en      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (amount == '0 || ctrl == OP_HOLD || ctrl == OP_RSVD)
                  state_nxt = S_DONE;
               else
                  state_nxt = S_RUN;
            end else begin
               q_en = 1'b1;
            end
         end
         S_RUN: begin
            step_op = op_q;
            q_en    = 1'b1;
            if (cnt == AMT_W'(1)) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // LOAD bursts collapse to a single step regardless of the requested count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q    <= '0;
         op_q <= OP_HOLD;
         cnt  <= '0;
      end else begin
         if (q_en) q <= q_step;
         if (state == S_IDLE && start) begin
            op_q <= ctrl;
            cnt  <= (ctrl == OP_LOAD && amount != '0) ? AMT_W'(1) : amount;
         end else if (state == S_RUN) begin
            cnt <= cnt - AMT_W'(1);
         end
      end
   end

   assign busy   = (state == S_RUN);
   assign done   = (state == S_DONE);
   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

`ifdef USR_PARITY_EN
   assign q_par = ^q;
`else
   assign q_par = 1'b0;
`endif

endmodule

// File: tb/tb_usr_shift_engine.sv
// Scoreboard bench for usr_shift_engine: directed plan plus randomized traffic vs. a behavioural model.
module tb_usr_shift_engine;

   localparam int W = 8;
   localparam int A = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [2:0]   ctrl = 3'd0;
   logic [W-1:0] d = '0;
   logic         sin_l = 1'b0;
   logic         sin_r = 1'b0;
   logic         start = 1'b0;
   logic [A-1:0] amount = '0;
   logic [W-1:0] q;
   logic         sout_l, sout_r, busy, done, q_par;

   usr_shift_engine #(.WIDTH(W), .AMT_W(A)) dut (
      .clk(clk), .reset(reset), .ctrl(ctrl), .d(d), .sin_l(sin_l), .sin_r(sin_r),
      .start(start), .amount(amount), .q(q), .sout_l(sout_l), .sout_r(sout_r),
      .busy(busy), .done(done), .q_par(q_par)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] q;
      logic         busy;
      logic         done;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   bit   stim_done = 0;

   // behavioural model: register value, steps remaining in a burst, pending done pulse
   int   m_q = 0;
   int   m_left = 0;
   bit   m_done = 0;
   int   m_op = 0;

   function automatic int apply(int op, int qv, int dv, bit sl, bit sr);
      int r;
      case (op)
         1: r = (qv / 2) + (sl ? 128 : 0);
         2: r = ((qv * 2) % 256) + (sr ? 1 : 0);
         3: r = (qv / 2) + ((qv % 2) * 128);
         4: r = ((qv * 2) % 256) + (qv / 128);
         5: r = (qv / 2) + (qv >= 128 ? 128 : 0);
         6: r = dv;
         default: r = qv;
      endcase
      return r;
   endfunction

   function automatic bit parity8(int v);
      bit p = 0;
      for (int i = 0; i < 8; i++) p ^= ((v >> i) & 1) != 0;
      return p;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock of stimulus; the model predicts the state after the coming edge
   task automatic cycle(input logic [2:0] c, input logic [W-1:0] dv, input bit sl, input bit sr,
                        input bit st, input logic [A-1:0] amt);
      exp_t e;
      @(negedge clk);
      ctrl = c; d = dv; sin_l = sl; sin_r = sr; start = st; amount = amt;
      if (m_left > 0) begin
         m_q = apply(m_op, m_q, dv, sl, sr);
         m_left--;
         if (m_left == 0) m_done = 1;
      end else if (m_done) begin
         m_done = 0;
      end else if (st) begin
         m_op = c;
         if (amt == 0 || c == 3'd0 || c == 3'd7) m_done = 1;
         else m_left = (c == 3'd6) ? 1 : int'(amt);
      end else begin
         m_q = apply(c, m_q, dv, sl, sr);
      end
      e.q = m_q[W-1:0];
      e.busy = (m_left > 0);
      e.done = m_done;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(3'd0, '0, 0, 0, 0, '0);
   endtask

   task automatic chk_q(input logic [W-1:0] exp, input string name);
      @(posedge clk); #2;
      check(name, q, exp);
   endtask

   // monitor: every clock the DUT presents a new register value; pop and compare it
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q", q, e.q);
            check("busy", busy, e.busy);
            check("done", done, e.done);
            check("sout_l", sout_l, e.q[W-1]);
            check("sout_r", sout_r, e.q[0]);
`ifdef USR_PARITY_EN
            check("q_par", q_par, parity8(e.q));
`else
            check("q_par", q_par, 0);
`endif
         end
      end
   end

   initial begin
      int wait_cnt;
      #1;
      check("reset_q", q, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // 1: direct LOAD then ROL
      cycle(3'd6, 8'hA5, 0, 0, 0, '0);
      chk_q(8'hA5, "load_a5");
      cycle(3'd4, '0, 0, 0, 0, '0);
      chk_q(8'h4B, "rol_4b");
      // 2: ROR burst of 3 from A5
      cycle(3'd6, 8'hA5, 0, 0, 0, '0);
      cycle(3'd3, '0, 0, 0, 1, 8'd3);
      chk_q(8'hA5, "ror_start_hold");
      cycle(3'd0, '0, 0, 0, 0, '0);
      chk_q(8'hD2, "ror1");
      cycle(3'd0, '0, 0, 0, 0, '0);
      chk_q(8'h69, "ror2");
      cycle(3'd0, '0, 0, 0, 0, '0);
      chk_q(8'hB4, "ror3");
      idle(2);
      // 3: ASR burst of 2 from 90, then SL fill of 8 from 00
      cycle(3'd6, 8'h90, 0, 0, 0, '0);
      cycle(3'd5, '0, 0, 0, 1, 8'd2);
      cycle(3'd0, '0, 0, 0, 0, '0);
      chk_q(8'hC8, "asr1");
      cycle(3'd0, '0, 0, 0, 0, '0);
      chk_q(8'hE4, "asr2");
      idle(1);
      cycle(3'd6, 8'h00, 0, 0, 0, '0);
      cycle(3'd2, '0, 0, 1, 1, 8'd8);
      for (int i = 0; i < 8; i++) cycle(3'd0, '0, 0, 1, 0, '0);
      chk_q(8'hFF, "sl_fill");
      idle(1);
      // 4: zero-length burst
      cycle(3'd1, '0, 1, 0, 1, 8'd0);
      idle(2);
      // 5: ctrl/start disturbance during RUN
      cycle(3'd6, 8'h3C, 0, 0, 0, '0);
      cycle(3'd4, '0, 0, 0, 1, 8'd4);
      for (int i = 0; i < 4; i++) cycle(3'd6, 8'hFF, 0, 0, 1, 8'd7);
      chk_q(8'hC3, "run_disturb");
      cycle(3'd6, 8'hFF, 0, 0, 1, 8'd7);
      idle(2);
      // 6: reset two steps into a 5-step SRL burst
      cycle(3'd1, '0, 1, 0, 1, 8'd5);
      cycle(3'd0, '0, 1, 0, 0, '0);
      cycle(3'd0, '0, 1, 0, 0, '0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_mid_q", q, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      m_q = 0; m_left = 0; m_done = 0; m_op = 0;
      @(negedge clk);
      reset = 1'b0;
      cycle(3'd6, 8'h81, 0, 0, 0, '0);
      cycle(3'd3, '0, 0, 0, 1, 8'd2);
      cycle(3'd0, '0, 0, 0, 0, '0);
      cycle(3'd0, '0, 0, 0, 0, '0);
      chk_q(8'h60, "post_rst_burst");
      // 7: parity points
      cycle(3'd6, 8'hA5, 0, 0, 0, '0);
      cycle(3'd6, 8'hA4, 0, 0, 0, '0);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit st = ($urandom_range(0, 5) == 0);
         cycle(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
               st, 8'($urandom_range(0, 12)));
      end
      idle(16);
      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      check("scoreboard_drained", sb.size(), 0);
      stim_done = 1;
   end

   initial begin
      #200000;
      if (!stim_done) begin
         failures++;
         $display("FAIL timeout: stimulus did not complete, got running expected finished");
      end
   end

   initial begin
      wait (stim_done || $time >= 200000);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
